// File: rtl/ula16_seq_arbiter.sv
// ula16_seq_arbiter: round-robin two-requester front end that runs 16-bit AND/OR/XOR/ADD
// through one shared 8-bit combinational ALU slice, low byte then high byte with carry chaining.
// Latency 3 cycles from the request handshake cycle to rsp_valid, at most one op per 4 cycles;
// the response is held until rsp_ready and both requesters see ready=0 outside IDLE.
// Optional build macro ULA16_SEQ_FLAGS_EN adds rsp_zero / rsp_carry status outputs.
module ula16_seq_arbiter #(
    parameter int W     = 16,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    // requester 0
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic [1:0]       req0_op,
    // requester 1
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    input  logic [1:0]       req1_op,
    // shared ALU slice
    output logic [SLICE-1:0] alu_a,
    output logic [SLICE-1:0] alu_b,
    output logic [1:0]       alu_op,
    output logic             alu_cin,
    input  logic [SLICE-1:0] alu_result,
    input  logic             alu_cout,
    // response channel
`ifdef ULA16_SEQ_FLAGS_EN
    output logic             rsp_zero,
    output logic             rsp_carry,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_data,
    output logic             rsp_id
);

    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [1:0]     r_op;
    logic           r_id;
    logic           r_last;
    logic           r_carry;
    logic [W-1:0]   r_res;

    logic           w_idle;
    logic           w_gnt0;
    logic           w_gnt1;
    logic           w_hs;
    logic [W-1:0]   w_sel_a;
    logic [W-1:0]   w_sel_b;
    logic [1:0]     w_sel_op;

    // Readies are gated by rst_n so nothing is offered while reset is asserted.
    assign w_idle = (r_state == S_IDLE) && rst_n;

    // Round robin: a lone requester always wins; on a tie the one not served last wins.
    assign w_gnt0 = req0_valid & (~req1_valid | r_last);
    assign w_gnt1 = req1_valid & (~req0_valid | ~r_last);

    assign req0_ready = w_idle & w_gnt0;
    assign req1_ready = w_idle & w_gnt1;
    assign w_hs       = req0_ready | req1_ready;

    assign w_sel_a  = w_gnt1 ? req1_a  : req0_a;
    assign w_sel_b  = w_gnt1 ? req1_b  : req0_b;
    assign w_sel_op = w_gnt1 ? req1_op : req0_op;

    assign rsp_data = r_res;
    assign rsp_id   = r_id;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus slice drive: each pass presents one byte; IDLE/DONE keep the slice at 0.
    always_comb begin
        w_state_nxt = r_state;
        alu_a       = '0;
        alu_b       = '0;
        alu_op      = 2'b00;
        alu_cin     = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    w_state_nxt = S_LOW;
                end
            end
            S_LOW: begin
                alu_a       = r_a[SLICE-1:0];
                alu_b       = r_b[SLICE-1:0];
                alu_op      = r_op;
                alu_cin     = 1'b0;
                w_state_nxt = S_HIGH;
            end
            S_HIGH: begin
                alu_a       = r_a[W-1:SLICE];
                alu_b       = r_b[W-1:SLICE];
                alu_op      = r_op;
                alu_cin     = r_carry;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand latch at grant, then byte-wise result capture; carry only chains for ADD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= 2'b00;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
            r_carry <= 1'b0;
            r_res   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_a    <= w_sel_a;
                        r_b    <= w_sel_b;
                        r_op   <= w_sel_op;
                        r_id   <= w_gnt1;
                        r_last <= w_gnt1;
                    end
                end
                S_LOW: begin
                    r_res[SLICE-1:0] <= alu_result;
                    r_carry          <= (r_op == OP_ADD) & alu_cout;
                end
                S_HIGH: begin
                    r_res[W-1:SLICE] <= alu_result;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ULA16_SEQ_FLAGS_EN
    logic r_flag_zero;
    logic r_flag_carry;

    assign rsp_zero  = r_flag_zero;
    assign rsp_carry = r_flag_carry;

    // Status flags settle on the HIGH pass so they are ready together with rsp_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_zero  <= 1'b0;
            r_flag_carry <= 1'b0;
        end else if (r_state == S_HIGH) begin
            r_flag_zero  <= ({alu_result, r_res[SLICE-1:0]} == '0);
            r_flag_carry <= (r_op == OP_ADD) & alu_cout;
        end
    end
`endif

endmodule

// File: tb/tb_ula16_seq_arbiter.sv
// Testbench for ula16_seq_arbiter: behavioural ALU slice, scoreboard of expected responses,
// per-pass checks of the slice drive, arbitration order, backpressure and reset abort.
module tb_ula16_seq_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [15:0] req0_a, req0_b;
    logic [1:0]  req0_op;
    logic        req1_valid, req1_ready;
    logic [15:0] req1_a, req1_b;
    logic [1:0]  req1_op;
    logic [7:0]  alu_a, alu_b, alu_result;
    logic [1:0]  alu_op;
    logic        alu_cin, alu_cout;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [15:0] rsp_data;
`ifdef ULA16_SEQ_FLAGS_EN
    logic        rsp_zero, rsp_carry;
`endif

    ula16_seq_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout),
`ifdef ULA16_SEQ_FLAGS_EN
        .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared 8-bit ALU slice
    logic [8:0] alu_sum;
    assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
    always_comb begin
        alu_result = 8'h00;
        alu_cout   = 1'b0;
        case (alu_op)
            2'b00: alu_result = alu_a & alu_b;
            2'b01: alu_result = alu_a | alu_b;
            2'b10: alu_result = alu_a ^ alu_b;
            default: begin
                alu_result = alu_sum[7:0];
                alu_cout   = alu_sum[8];
            end
        endcase
    end

    typedef struct packed {
        logic        id;
        logic [15:0] data;
    } sb_t;

    sb_t         exp_q[$];
    bit          grant_log[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          hs_cyc  = -100;
    int          hs_cnt  = 0;
    logic [15:0] cur_a, cur_b;
    logic [1:0]  cur_op;
    logic        cur_cin;
    logic [15:0] last_data;
    logic        last_id;

    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] op);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return a + b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample mid-cycle, score handshakes and responses, advance past the edge.
    task automatic tick();
        sb_t        e;
        logic       id;
        logic [8:0] lo;
        #1;
        check("one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
        if (rsp_valid)
            check("rdy_in_done", {30'd0, req0_ready, req1_ready}, 32'd0);
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
            id      = req1_valid && req1_ready;
            cur_a   = id ? req1_a  : req0_a;
            cur_b   = id ? req1_b  : req0_b;
            cur_op  = id ? req1_op : req0_op;
            lo      = {1'b0, cur_a[7:0]} + {1'b0, cur_b[7:0]};
            cur_cin = (cur_op == 2'b11) ? lo[8] : 1'b0;
            e.id    = id;
            e.data  = model(cur_a, cur_b, cur_op);
            exp_q.push_back(e);
            grant_log.push_back(id);
            hs_cyc  = cyc;
            hs_cnt++;
        end else if (cyc == hs_cyc + 1) begin
            check("low_drive", {alu_a, alu_b, 6'd0, alu_op, 7'd0, alu_cin},
                  {cur_a[7:0], cur_b[7:0], 6'd0, cur_op, 8'd0});
            check("low_valid", {31'd0, rsp_valid}, 32'd0);
        end else if (cyc == hs_cyc + 2) begin
            check("high_drive", {alu_a, alu_b, 6'd0, alu_op, 7'd0, alu_cin},
                  {cur_a[15:8], cur_b[15:8], 6'd0, cur_op, 7'd0, cur_cin});
            check("high_valid", {31'd0, rsp_valid}, 32'd0);
        end else if (cyc == hs_cyc + 3) begin
            check("latency", {31'd0, rsp_valid}, 32'd1);
            check("done_drive", {alu_a, alu_b, 6'd0, alu_op, 7'd0, alu_cin}, 32'd0);
        end
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
                check("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
                last_data = rsp_data;
                last_id   = rsp_id;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 20) begin
            tick();
            n++;
        end
        check("drain_timeout", exp_q.size(), 32'd0);
    endtask

    task automatic do_op(input bit id, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op);
        int n     = 0;
        int start = hs_cnt;
        if (id) begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end
        while (hs_cnt == start && n < 20) begin
            tick();
            n++;
        end
        check("grant_timeout", hs_cnt - start, 32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        rst_n      = 1'b0;
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_a = 16'h0; req0_b = 16'h0; req0_op = 2'b00;
        req1_valid = 1'b1; req1_a = 16'h0; req1_b = 16'h0; req1_op = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        // reset state, with both requesters asking
        check("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        check("rst_rsp", {14'd0, rsp_valid, rsp_id, rsp_data}, 32'd0);
        check("rst_alu", {alu_a, alu_b, 6'd0, alu_op, 7'd0, alu_cin}, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n      = 1'b1;
        repeat (2) tick();
        check("idle_ready", {30'd0, req0_ready, req1_ready}, 32'd0);

        // arbitration: both valid continuously, XOR, grants 0,1,0,1
        grant_log.delete();
        req0_a = 16'hA5A5; req0_b = 16'h0F0F; req0_op = 2'b10;
        req1_a = 16'h1234; req1_b = 16'hFFFF; req1_op = 2'b10;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        n = 0;
        while (hs_cnt < 4 && n < 40) begin
            tick();
            n++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();
        check("arb_count", grant_log.size(), 32'd4);
        for (int i = 0; i < grant_log.size(); i++)
            check("arb_grant", {31'd0, grant_log[i]}, i % 2);

        // single OR from requester 0
        do_op(1'b0, 16'hF00F, 16'h0FF0, 2'b01);
        drain();
        check("or_result", {15'd0, last_id, last_data}, {15'd0, 1'b0, 16'hFFFF});

        // ADD carry chain from requester 1
        do_op(1'b1, 16'h00FF, 16'h0001, 2'b11);
        drain();
        check("add_chain", {15'd0, last_id, last_data}, {15'd0, 1'b1, 16'h0100});
`ifdef ULA16_SEQ_FLAGS_EN
        check("add_chain_flags", {30'd0, rsp_zero, rsp_carry}, 32'd0);
`endif

        // ADD wrap
        do_op(1'b0, 16'hFFFF, 16'h0001, 2'b11);
        drain();
        check("add_wrap", {16'd0, last_data}, 32'd0);
`ifdef ULA16_SEQ_FLAGS_EN
        check("add_wrap_flags", {30'd0, rsp_zero, rsp_carry}, 32'd3);
`endif

        // backpressure: AND response held for 5 cycles with rsp_ready low
        rsp_ready = 1'b0;
        do_op(1'b0, 16'h1234, 16'h00FF, 2'b00);
        n = 0;
        while (!rsp_valid && n < 10) begin
            tick();
            n++;
        end
        check("bp_valid_seen", {31'd0, rsp_valid}, 32'd1);
        req1_a = 16'h0F0F; req1_b = 16'h00F0; req1_op = 2'b01;
        req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold", {13'd0, rsp_valid, req0_ready, req1_ready, rsp_data},
                  {13'd0, 3'b100, 16'h0034});
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_release", {16'd0, last_data}, {16'd0, 16'h0034});
        n = hs_cnt;
        base = 0;
        while (hs_cnt == n && base < 10) begin
            tick();
            base++;
        end
        check("bp_next_grant", {31'd0, grant_log[grant_log.size()-1]}, 32'd1);
        req1_valid = 1'b0;
        drain();

        // reset during the HIGH pass
        do_op(1'b1, 16'h1111, 16'h2222, 2'b11);
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_rsp", {14'd0, rsp_valid, rsp_id, rsp_data}, 32'd0);
        check("midrst_alu", {alu_a, alu_b, 6'd0, alu_op, 7'd0, alu_cin}, 32'd0);
        check("midrst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        hs_cyc = -100;
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        req0_a = 16'h00F0; req0_b = 16'h0F00; req0_op = 2'b10;
        req1_a = 16'h0001; req1_b = 16'h0002; req1_op = 2'b11;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        n = hs_cnt;
        base = 0;
        while (hs_cnt == n && base < 10) begin
            tick();
            base++;
        end
        check("midrst_grant0", {31'd0, grant_log[grant_log.size()-1]}, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
